instruction_fetch_unit: RTL and testbench

//  Fetch stage of the single-issue RISC-V core, directly upstream of instruction_memory.

---
 rtl/instruction_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage of the single-issue RISC-V core. Owns the program
//               counter, presents it to instruction_memory, and captures the
//               returned (combinational) instruction word into the IF/ID
//               register. {pc, instr} is handed to decode over valid/ready.
//               The stage also handles stall, redirect, halt and out-of-range
//               fetch.
// Ports       : clk, reset (sync, active-high)
//               pc (out)                    fetch address to memory
//               instruction_code (in)       instruction word at pc
//               redirect_valid/redirect_pc  branch/jump redirect
//               halt_req (in)               stop fetching
//               id_ready (in) / id_valid, id_instr, id_pc (out)  decode port
//               halted (out)                FSM is in HALT
//               fetch_fault (out)           sticky out-of-range fetch flag
//               misalign_trap (out)         only with FETCH_MISALIGN_TRAP_EN
// Config      : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned redirect
//               traps (1-cycle misalign_trap pulse, enter HALT) instead of
//               having its low two bits forced to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        fetch_fault
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic       misalign_trap
`endif
);

  // Highest word address that still lies inside instruction memory.
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        fault_q, fault_d;
  logic        trap_q, trap_d;

  logic        fire;
  logic        redirect_misaligned;
  logic [31:0] redirect_aligned;

  assign fire             = (state_q == RUN) && (!id_valid_q || id_ready);
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign misalign_trap       = trap_q;
`else
  // Without the trap option the low bits are simply discarded.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_misaligned  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    fault_d    = fault_q;
    trap_d     = 1'b0;

    // A held entry that decode takes this cycle is retired unless a new
    // capture below replaces it.
    if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end

    case (state_q)
      BOOT: begin
        // One idle cycle after reset so memory contents settle before use.
        state_d = RUN;
      end

      RUN: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          if (redirect_misaligned) begin
            trap_d  = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = redirect_aligned;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end else if (fire && (pc_q > LAST_PC)) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (fire) begin
          id_instr_d = instruction_code;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end

      HALT: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          if (redirect_misaligned) begin
            trap_d = 1'b1;
          end else begin
            pc_d    = redirect_aligned;
            fault_d = 1'b0;
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'd0;
      fault_q    <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      fault_q    <= fault_d;
      trap_q     <= trap_d;
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  // The trap flop has no consumer in this build.
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

  assign pc          = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit with
//               an 8-word combinational instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        fetch_fault;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  logic [31:0] mem [8];
  assign instruction_code = mem[pc[4:2]];

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(32),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .instruction_code(instruction_code),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .halted          (halted),
    .fetch_fault     (fetch_fault)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.misalign_trap  (misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] ipc,
                          input logic [31:0] instr, input logic [31:0] npc);
    check_eq({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    check_eq({tag, ".id_pc"}, id_pc, ipc);
    check_eq({tag, ".id_instr"}, id_instr, instr);
    check_eq({tag, ".pc"}, pc, npc);
  endtask

  task automatic check_reset_state(input string tag);
    check_id(tag, 1'b0, 32'h0, NOP, 32'h0);
    check_eq({tag, ".halted"}, {31'd0, halted}, 32'd0);
    check_eq({tag, ".fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    mem[0] = 32'h0094_0333; mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113; mem[3] = 32'h0030_0193;
    mem[4] = 32'h0040_0213; mem[5] = 32'h0050_0293;
    mem[6] = 32'h0060_0313; mem[7] = 32'h0070_0393;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt_req = 1'b0; id_ready = 1'b1;

    // Reset, BOOT cycle, first fetch
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();
    check_id("boot", 1'b0, 32'h0, NOP, 32'h0);
    step();
    check_id("fetch0", 1'b1, 32'h0, 32'h0094_0333, 32'h4);
    step();
    check_id("fetch1", 1'b1, 32'h4, mem[1], 32'h8);

    // Stall for three cycles, then release
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_id("stall", 1'b1, 32'h4, mem[1], 32'h8);
    end
    id_ready = 1'b1;
    step();
    check_id("unstall", 1'b1, 32'h8, mem[2], 32'hC);

    // Redirect during stall, with a simultaneous halt request
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10; halt_req = 1'b1;
    step();
    check_eq("redir.id_valid", {31'd0, id_valid}, 32'd0);
    check_eq("redir.pc", pc, 32'h10);
    check_eq("redir.halted", {31'd0, halted}, 32'd0);
    redirect_valid = 1'b0; halt_req = 1'b0; id_ready = 1'b1;
    step();
    check_id("redir_fetch", 1'b1, 32'h10, mem[4], 32'h14);

    // Run off the end of memory
    step(); check_id("run14", 1'b1, 32'h14, mem[5], 32'h18);
    step(); check_id("run18", 1'b1, 32'h18, mem[6], 32'h1C);
    step(); check_id("run1c", 1'b1, 32'h1C, mem[7], 32'h20);
    step();
    check_eq("oor.fault", {31'd0, fetch_fault}, 32'd1);
    check_eq("oor.halted", {31'd0, halted}, 32'd1);
    check_eq("oor.id_pc", id_pc, 32'h1C);
    check_eq("oor.pc", pc, 32'h20);
    check_eq("oor.id_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    check_eq("rec.fault", {31'd0, fetch_fault}, 32'd0);
    check_eq("rec.halted", {31'd0, halted}, 32'd0);
    check_eq("rec.pc", pc, 32'h0);
    redirect_valid = 1'b0;
    step(); check_id("rec_fetch0", 1'b1, 32'h0, mem[0], 32'h4);
    step(); check_id("rec_fetch4", 1'b1, 32'h4, mem[1], 32'h8);

    // Halt request at pc=8
    halt_req = 1'b1;
    step();
    check_eq("halt.halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("halt.pc", pc, 32'h8);
      check_eq("halt.id_valid", {31'd0, id_valid}, 32'd0);
      step();
    end
    check_eq("halt.still", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    check_eq("resume.halted", {31'd0, halted}, 32'd0);
    check_eq("resume.pc", pc, 32'h8);
    redirect_valid = 1'b0;
    step();
    check_id("resume_fetch", 1'b1, 32'h8, mem[2], 32'hC);

    // Reset asserted while halted
    halt_req = 1'b1;
    step();
    check_eq("halt2.halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0; reset = 1'b1;
    step();
    check_reset_state("rst_halt");
    reset = 1'b0;
    step();
    check_id("boot2", 1'b0, 32'h0, NOP, 32'h0);
    step();
    check_id("boot2_fetch", 1'b1, 32'h0, mem[0], 32'h4);

    // Misaligned redirect target 0x6 (pc currently 4)
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("mis.trap", {31'd0, misalign_trap}, 32'd1);
    check_eq("mis.halted", {31'd0, halted}, 32'd1);
    check_eq("mis.pc", pc, 32'h4);
    check_eq("mis.id_valid", {31'd0, id_valid}, 32'd0);
    step();
    check_eq("mis.trap_pulse", {31'd0, misalign_trap}, 32'd0);
    check_eq("mis.halted2", {31'd0, halted}, 32'd1);
`else
    check_eq("mis.pc", pc, 32'h4);
    check_eq("mis.id_valid", {31'd0, id_valid}, 32'd0);
    check_eq("mis.halted", {31'd0, halted}, 32'd0);
    step();
    check_id("mis_fetch", 1'b1, 32'h4, mem[1], 32'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
